// File: rtl/stream_mux_nx1.sv
// N-channel to 1 registered stream mux with fixed-select or round-robin grant.
// Optional out_parity output when STREAM_MUX_PARITY_EN is defined.

module stream_mux_nx1_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             load,
  input  logic             gnt_vld,
  input  logic [SEL_W-1:0] gnt_idx,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_masked
);
  logic hit;

  assign hit         = gnt_vld && (gnt_idx == SEL_W'(IDX));
  assign ready       = load && hit;
  // Non-granted lanes contribute zero so the data mux reduces to an OR tree.
  assign data_masked = hit ? data : '0;
endmodule

module stream_mux_nx1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                  out_parity
`endif
);
  localparam int SEL_N = 1 << SEL_W;

  logic                        load;
  logic                        gnt_vld;
  logic [SEL_W-1:0]            gnt_idx;
  logic [WIDTH-1:0]            gnt_data;
  logic [N_CH-1:0][WIDTH-1:0]  masked;
  logic [SEL_N-1:0]            valid_pad;

  logic                        out_valid_q, out_valid_d;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic [SEL_W-1:0]            out_ch_q, out_ch_d;
  logic [SEL_W-1:0]            rr_ptr_q, rr_ptr_d;

  assign load      = !out_valid_q || out_ready;
  // Padding lets an out-of-range sel index a defined zero bit.
  assign valid_pad = SEL_N'(in_valid);

  always_comb begin
    logic [SEL_W:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!mode) begin
      if (({1'b0, sel} < (SEL_W+1)'(N_CH)) && valid_pad[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      // Scan starts one past the last winner and wraps modulo N_CH.
      for (int k = 1; k <= N_CH; k++) begin
        cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(N_CH))
          cand = cand - (SEL_W+1)'(N_CH);
        if (!gnt_vld && valid_pad[cand[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    stream_mux_nx1_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .IDX   (i)
    ) u_lane (
      .load        (load),
      .gnt_vld     (gnt_vld),
      .gnt_idx     (gnt_idx),
      .data        (in_data[i*WIDTH +: WIDTH]),
      .ready       (in_ready[i]),
      .data_masked (masked[i])
    );
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++)
      gnt_data = gnt_data | masked[i];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
        if (mode)
          rr_ptr_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (load && gnt_vld)
      parity_d = ^gnt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif
endmodule
